code_fetch_decompressor: RTL and testbench

- Responder side of the processor's instruction-fetch path.
- Reads a dictionary-compressed code image from the instruction memory port and expands each 16-bit token back into a 32-bit instruction.
- Delivers instructions to the IF stage over a valid/ready handshake.
- Accepts jump redirects from EX (PCSource plus target) and restarts the stream at the new compressed address.

---
 rtl/code_fetch_decompressor.sv | 168 ++++++++++++++++
 tb/tb_code_fetch_decompressor.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_fetch_decompressor.sv
// Instruction-fetch responder: streams a dictionary-compressed code image from memory
// and expands 16-bit tokens into 32-bit instructions over a valid/ready handshake.
module code_fetch_decompressor #(
    parameter int unsigned DICT_AW = 4,
    parameter int unsigned BUF_HW  = 6,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               dict_we,
    input  logic [DICT_AW-1:0] dict_addr,
    input  logic [31:0]        dict_wdata,
    output logic               mem_req,
    output logic [ADDR_W-2:0]  mem_addr,
    input  logic [31:0]        mem_rdata,
    input  logic               jump_en,
    input  logic [ADDR_W-1:0]  jump_addr,
    output logic [31:0]        instr_out,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready
);

    localparam int unsigned PW = $clog2(BUF_HW);
    localparam int unsigned CW = $clog2(BUF_HW + 1);
    localparam int unsigned MW = ADDR_W - 1;

    typedef logic [PW-1:0] ptr_t;

    function automatic ptr_t ptr_add(input ptr_t p, input int unsigned k);
        int unsigned s;
        s = 32'(p) + k;
        if (s >= BUF_HW) s = s - BUF_HW;
        return ptr_t'(s);
    endfunction

    logic [31:0]       dict_q [2**DICT_AW];
    logic [15:0]       buf_q [BUF_HW];
    logic [15:0]       buf_d [BUF_HW];
    ptr_t              rd_ptr_q, rd_ptr_d;
    ptr_t              wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [MW-1:0]     fptr_q, fptr_d;
    logic [MW-1:0]     mem_addr_q, mem_addr_d;
    logic              mem_req_q, mem_req_d;
    logic              pending_q, pending_d;
    logic              skip_lo_q, skip_lo_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic [31:0]       instr_out_q, instr_out_d;
    logic              instr_valid_q, instr_valid_d;

    logic [15:0]       next_hw1, next_hw2;
    logic [31:0]       dec_instr;
    logic              tok_hit, tok_ready, out_free, decode, issue;
    int unsigned       cnt_now, consume_n, push_n, inflight, free_slots;

    // Dictionary survives reset; a decode in the write cycle still sees the old entry.
    always_ff @(posedge clk) begin
        if (dict_we) dict_q[dict_addr] <= dict_wdata;
    end

    always_comb begin
        next_hw1  = buf_q[ptr_add(rd_ptr_q, 1)];
        next_hw2  = buf_q[ptr_add(rd_ptr_q, 2)];
        cnt_now   = 32'(cnt_q);
        tok_hit   = buf_q[rd_ptr_q][15];
        tok_ready = tok_hit ? (cnt_now >= 1) : (cnt_now >= 3);
        out_free  = !instr_valid_q || instr_ready;
        decode    = tok_ready && out_free && !jump_en;
        consume_n = decode ? (tok_hit ? 1 : 3) : 0;
        dec_instr = tok_hit ? dict_q[buf_q[rd_ptr_q][DICT_AW-1:0]] : {next_hw1, next_hw2};

        buf_d  = buf_q;
        push_n = 0;
        if (pending_q && !jump_en) begin
            if (skip_lo_q) begin
                buf_d[wr_ptr_q] = mem_rdata[31:16];
                push_n = 1;
            end else begin
                buf_d[wr_ptr_q]             = mem_rdata[15:0];
                buf_d[ptr_add(wr_ptr_q, 1)] = mem_rdata[31:16];
                push_n = 2;
            end
        end

        // Each outstanding read may still deliver two halfwords, so reserve room for them.
        inflight   = 32'(mem_req_q) + 32'(pending_q);
        free_slots = BUF_HW - (cnt_now - consume_n);
        issue      = start && !jump_en && (free_slots >= 2 + 2 * inflight);

        mem_req_d  = issue;
        mem_addr_d = mem_addr_q;
        fptr_d     = fptr_q;
        if (issue) begin
            mem_addr_d = fptr_q;
            fptr_d     = fptr_q + MW'(1);
        end
        pending_d = mem_req_q && !jump_en;
        skip_lo_d = skip_lo_q;
        if (pending_q && skip_lo_q) skip_lo_d = 1'b0;

        rd_ptr_d      = ptr_add(rd_ptr_q, consume_n);
        wr_ptr_d      = ptr_add(wr_ptr_q, push_n);
        cnt_d         = CW'(cnt_now - consume_n + push_n);
        instr_out_d   = instr_out_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        pc_d          = pc_q;

        if (jump_en) begin
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
            cnt_d         = '0;
            instr_valid_d = 1'b0;
            pc_d          = jump_addr;
            fptr_d        = jump_addr[ADDR_W-1:1];
            skip_lo_d     = jump_addr[0];
        end else if (decode) begin
            instr_out_d   = dec_instr;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + (tok_hit ? ADDR_W'(1) : ADDR_W'(3));
        end else if (instr_ready) begin
            instr_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < BUF_HW; i++) buf_q[i] <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            cnt_q         <= '0;
            fptr_q        <= '0;
            mem_addr_q    <= '0;
            mem_req_q     <= 1'b0;
            pending_q     <= 1'b0;
            skip_lo_q     <= 1'b0;
            pc_q          <= '0;
            instr_pc_q    <= '0;
            instr_out_q   <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            buf_q         <= buf_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            cnt_q         <= cnt_d;
            fptr_q        <= fptr_d;
            mem_addr_q    <= mem_addr_d;
            mem_req_q     <= mem_req_d;
            pending_q     <= pending_d;
            skip_lo_q     <= skip_lo_d;
            pc_q          <= pc_d;
            instr_pc_q    <= instr_pc_d;
            instr_out_q   <= instr_out_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr_out   = instr_out_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_code_fetch_decompressor.sv
// Bench for code_fetch_decompressor: directed pins plus a randomized run checked against
// a token-stream model computed directly from the memory image and dictionary.
module tb_code_fetch_decompressor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        dict_we = 1'b0;
    logic [3:0]  dict_addr = '0;
    logic [31:0] dict_wdata = '0;
    logic        mem_req;
    logic [30:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        jump_en = 1'b0;
    logic [31:0] jump_addr = '0;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;

    int          checks = 0;
    int          errors = 0;
    int unsigned hs_count = 0;
    bit          model_on = 1'b1;
    logic [31:0] mem_img [256];
    logic [31:0] mdict [16];

    code_fetch_decompressor #(.DICT_AW(4), .BUF_HW(6), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst_n), .start(start),
        .dict_we(dict_we), .dict_addr(dict_addr), .dict_wdata(dict_wdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .jump_en(jump_en), .jump_addr(jump_addr),
        .instr_out(instr_out), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timeout, got no event expected one", name);
    endtask

    task automatic wait_valid(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (instr_valid === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) timeout_fail(name);
    endtask

    task automatic wait_req(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (mem_req === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) timeout_fail(name);
    endtask

    task automatic wait_pc(input string name, input logic [31:0] pc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (instr_valid === 1'b1 && instr_pc === pc) begin ok = 1'b1; break; end
        end
        if (!ok) timeout_fail(name);
    endtask

    function automatic logic [15:0] hw(input logic [31:0] h);
        logic [31:0] w;
        w = mem_img[h[8:1]];
        return h[0] ? w[31:16] : w[15:0];
    endfunction

    // Memory: data for a request seen in one cycle is presented during the next cycle.
    initial begin
        logic       rq;
        logic [7:0] ra;
        rq = 1'b0;
        ra = '0;
        forever begin
            tick();
            mem_rdata = rq ? mem_img[ra] : $urandom();
            rq = mem_req;
            ra = mem_addr[7:0];
        end
    end

    // Per-cycle compare against the token-stream model.
    initial begin
        logic [31:0] mpc, held_out, held_pc, einst;
        logic [30:0] mfetch;
        logic [15:0] t;
        bit          prev_hold, prev_jump, prev_nostart;
        mpc = '0; mfetch = '0; held_out = '0; held_pc = '0;
        prev_hold = 1'b0; prev_jump = 1'b0; prev_nostart = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                mpc = '0; mfetch = '0;
                prev_hold = 1'b0; prev_jump = 1'b0; prev_nostart = 1'b0;
                continue;
            end
            if (prev_jump) begin
                chk("valid_after_jump", 32'(instr_valid), 32'd0);
                chk("req_after_jump", 32'(mem_req), 32'd0);
            end
            if (prev_nostart) chk("req_after_start_low", 32'(mem_req), 32'd0);
            if (mem_req === 1'b1) begin
                chk("mem_addr_seq", 32'(mem_addr), 32'(mfetch));
                mfetch = mfetch + 31'd1;
            end
            if (prev_hold) begin
                chk("hold_valid", 32'(instr_valid), 32'd1);
                chk("hold_instr", instr_out, held_out);
                chk("hold_pc", instr_pc, held_pc);
            end
            if (instr_valid === 1'b1 && instr_ready === 1'b1 && jump_en === 1'b0) begin
                hs_count++;
                if (model_on) begin
                    t = hw(mpc);
                    if (t[15]) einst = mdict[t[3:0]];
                    else       einst = {hw(mpc + 32'd1), hw(mpc + 32'd2)};
                    chk("stream_instr", instr_out, einst);
                    chk("stream_pc", instr_pc, mpc);
                    mpc = mpc + (t[15] ? 32'd1 : 32'd3);
                end
            end
            prev_hold    = (instr_valid === 1'b1) && (instr_ready === 1'b0) && (jump_en === 1'b0);
            held_out     = instr_out;
            held_pc      = instr_pc;
            prev_jump    = (jump_en === 1'b1);
            prev_nostart = (start === 1'b0);
            if (jump_en === 1'b1) begin
                mpc    = jump_addr;
                mfetch = jump_addr[31:1];
            end
        end
    end

    initial begin
        bit          ok;
        logic [31:0] hold_out, hold_pc;
        logic [15:0] lo, hi;

        for (int i = 0; i < 256; i++) mem_img[i] = 32'h8003_8003;
        mem_img[1]  = 32'h1234_0000;
        mem_img[2]  = 32'hFFFF_5678;
        mem_img[4]  = 32'h8005_8003;
        mem_img[30] = 32'h0000_8003;
        for (int i = 0; i < 16; i++) mdict[i] = $urandom();
        mdict[3]  = 32'hA5A5_0001;
        mdict[5]  = 32'h5555_AAAA;
        mdict[15] = 32'hCAFE_F00D;

        repeat (3) tick();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr_out, 32'd0);
        chk("rst_pc", instr_pc, 32'd0);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            dict_we = 1'b1; dict_addr = 4'(i); dict_wdata = mdict[i];
            tick();
        end
        dict_we = 1'b0;

        // Hit stream and latency
        instr_ready = 1'b1;
        start = 1'b1;
        tick();
        chk("lat_req", 32'(mem_req), 32'd1);
        chk("lat_addr", 32'(mem_addr), 32'd0);
        tick();
        chk("lat_e1_valid", 32'(instr_valid), 32'd0);
        tick();
        chk("lat_e2_valid", 32'(instr_valid), 32'd0);
        tick();
        chk("lat_e3_valid", 32'(instr_valid), 32'd1);
        chk("hit0_instr", instr_out, 32'hA5A5_0001);
        chk("hit0_pc", instr_pc, 32'd0);
        tick();
        chk("hit1_valid", 32'(instr_valid), 32'd1);
        chk("hit1_instr", instr_out, 32'hA5A5_0001);
        chk("hit1_pc", instr_pc, 32'd1);

        // Escape token
        wait_pc("esc_wait", 32'd2, ok);
        if (ok) chk("esc_instr", instr_out, 32'h1234_5678);
        wait_valid("esc_next", ok);
        if (ok) begin
            chk("esc_next_pc", instr_pc, 32'd5);
            chk("esc_next_instr", instr_out, 32'hCAFE_F00D);
        end

        // Backpressure
        instr_ready = 1'b0;
        hold_out = instr_out;
        hold_pc  = instr_pc;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 32'(instr_valid), 32'd1);
            chk("bp_instr", instr_out, hold_out);
            chk("bp_pc", instr_pc, hold_pc);
        end
        chk("bp_req_stalled", 32'(mem_req), 32'd0);
        instr_ready = 1'b1;
        tick();
        chk("bp_release_valid", 32'(instr_valid), 32'd1);
        chk("bp_release_pc", instr_pc, hold_pc + 32'd1);
        chk("bp_release_instr", instr_out, 32'hA5A5_0001);

        // Redirect while a read is in flight
        wait_req("jmp_find_req", ok);
        jump_en = 1'b1; jump_addr = 32'd9;
        tick();
        jump_en = 1'b0;
        chk("jmp_valid_cleared", 32'(instr_valid), 32'd0);
        wait_req("jmp_req", ok);
        if (ok) chk("jmp_mem_addr", 32'(mem_addr), 32'd4);
        wait_valid("jmp_first", ok);
        if (ok) begin
            chk("jmp_first_pc", instr_pc, 32'd9);
            chk("jmp_first_instr", instr_out, 32'h5555_AAAA);
        end

        // Reset with only the escape halfword buffered
        jump_en = 1'b1; jump_addr = 32'd61;
        tick();
        jump_en = 1'b0;
        wait_req("rsterr_req", ok);
        if (ok) chk("rsterr_mem_addr", 32'(mem_addr), 32'd30);
        tick();
        tick();
        chk("escape_waits", 32'(instr_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_req", 32'(mem_req), 32'd0);
        chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
        chk("midrst_valid", 32'(instr_valid), 32'd0);
        chk("midrst_instr", instr_out, 32'd0);
        chk("midrst_pc", instr_pc, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        wait_valid("after_rst", ok);
        if (ok) begin
            chk("after_rst_pc", instr_pc, 32'd0);
            chk("after_rst_instr", instr_out, 32'hA5A5_0001);
        end

        // Dictionary rewrite coinciding with a decode of the same entry
        instr_ready = 1'b0;
        jump_en = 1'b1; jump_addr = 32'd12;
        tick();
        jump_en = 1'b0;
        wait_valid("rw_first", ok);
        if (ok) chk("rw_first_pc", instr_pc, 32'd12);
        repeat (4) tick();
        model_on = 1'b0;
        instr_ready = 1'b1;
        dict_we = 1'b1; dict_addr = 4'd3; dict_wdata = 32'h0000_00FF;
        tick();
        dict_we = 1'b0;
        instr_ready = 1'b0;
        mdict[3] = 32'h0000_00FF;
        chk("rw_old_pc", instr_pc, 32'd13);
        chk("rw_old_instr", instr_out, 32'hA5A5_0001);
        instr_ready = 1'b1;
        tick();
        chk("rw_new_pc", instr_pc, 32'd14);
        chk("rw_new_instr", instr_out, 32'h0000_00FF);
        jump_en = 1'b1; jump_addr = 32'd0; model_on = 1'b1;
        tick();
        jump_en = 1'b0;

        // Randomized run against the model
        start = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) begin
            lo = 16'($urandom());
            hi = 16'($urandom());
            lo[15] = ($urandom_range(0, 3) != 0);
            hi[15] = ($urandom_range(0, 3) != 0);
            mem_img[i] = {hi, lo};
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            mdict[i] = $urandom();
            dict_we = 1'b1; dict_addr = 4'(i); dict_wdata = mdict[i];
            tick();
        end
        dict_we = 1'b0;
        hs_count = 0;
        for (int c = 0; c < 3000; c++) begin
            instr_ready = ($urandom_range(0, 9) < 7);
            start       = ($urandom_range(0, 19) != 0);
            jump_en     = ($urandom_range(0, 39) == 0);
            if (jump_en) begin
                if ($urandom_range(0, 4) == 0) jump_addr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                else                           jump_addr = 32'($urandom_range(0, 511));
            end
            tick();
        end
        jump_en = 1'b0;
        start = 1'b0;
        instr_ready = 1'b1;
        repeat (5) tick();
        chk("random_progress", 32'(hs_count > 300), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
